// File: rtl/rsa_two_power_mod_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_two_power_mod_arbiter
//
// Shares one RSATwoPowerMod engine (2^power mod modulus) between NUM_REQ
// requesters. A round-robin arbiter grants one requester, latches its
// payload, runs a single engine handshake and returns the result on the
// shared rsp_out bus, qualified by that requester's rsp_valid bit only.
// power == 0 is answered locally with 1 and never reaches the engine.
//
// Optional build macro:
//   RSA_TPM_CACHE_EN - one-entry result cache {valid, power, modulus, result},
//                      filled on every engine completion. A granted request
//                      matching the entry is answered without the engine.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (ready one-hot/0)
//   req_in                 per-requester payload {power, modulus}
//   rsp_valid/rsp_ready    per-requester result handshake (valid one-hot/0)
//   rsp_out                shared result bus
//   e_i_valid/e_i_ready    engine input handshake, e_i_in = latched payload
//   e_o_valid/e_o_ready    engine result handshake, e_o_out = engine result
// ---------------------------------------------------------------------------
package rsa_two_power_mod_pkg;
  localparam int unsigned RSA_W = 32;

  typedef struct packed {
    logic [RSA_W-1:0] power;
    logic [RSA_W-1:0] modulus;
  } rsa_tpm_in_t;

  typedef struct packed {
    logic [RSA_W-1:0] result;
  } rsa_tpm_out_t;
endpackage

module rsa_two_power_mod_arbiter
  import rsa_two_power_mod_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  rsa_tpm_in_t        req_in [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output rsa_tpm_out_t       rsp_out,
  output logic               e_i_valid,
  input  logic               e_i_ready,
  output rsa_tpm_in_t        e_i_in,
  input  logic               e_o_valid,
  output logic               e_o_ready,
  input  rsa_tpm_out_t       e_o_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_q;
  rsa_tpm_in_t      payload_q;
  rsa_tpm_out_t     result_q;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  rsa_tpm_in_t      win_payload;
  logic             cache_hit;
  rsa_tpm_out_t     cache_result;

  // Round-robin search: start one past the last winner and wrap, so the
  // most recently served requester has the lowest priority.
  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_payload = req_in[win_idx];

  // Ready is only offered in IDLE and never while reset is held, so a
  // requester cannot see a handshake the FSM does not take.
  always_comb begin
    req_ready = '0;
    if (rst && state_q == IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign e_i_valid = (state_q == ISSUE);
  assign e_o_ready = (state_q == WAIT);
  assign e_i_in    = payload_q;
  assign rsp_out   = result_q;

`ifdef RSA_TPM_CACHE_EN
  logic         cache_valid_q;
  rsa_tpm_in_t  cache_key_q;
  rsa_tpm_out_t cache_result_q;

  assign cache_hit    = cache_valid_q && (win_payload == cache_key_q);
  assign cache_result = cache_result_q;

  // NOTE: the cache entry is reset because its valid bit gates reuse; a
  // stale entry after reset would answer without ever asking the engine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q  <= 1'b0;
      cache_key_q    <= '0;
      cache_result_q <= '0;
    end else if (state_q == WAIT && e_o_valid) begin
      cache_valid_q  <= 1'b1;
      cache_key_q    <= payload_q;
      cache_result_q <= e_o_out;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      payload_q <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q   <= win_idx;
            last_q    <= win_idx;
            payload_q <= win_payload;
            // Zero exponent is answered locally and takes precedence over
            // the cache, which it never fills.
            if (win_payload.power == '0) begin
              result_q <= '{result: RSA_W'(1)};
              state_q  <= RESP;
            end else if (cache_hit) begin
              result_q <= cache_result;
              state_q  <= RESP;
            end else begin
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (e_i_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (e_o_valid) begin
            result_q <= e_o_out;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_two_power_mod_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for rsa_two_power_mod_arbiter: a behavioural engine with random
// ready/latency, two requesters, and a scoreboard of expected responses
// pushed at each request handshake and compared while a response is shown.
// ---------------------------------------------------------------------------
module tb_rsa_two_power_mod_arbiter;
  import rsa_two_power_mod_pkg::*;

  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  rsa_tpm_in_t        req_in [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] rsp_ready;
  rsa_tpm_out_t       rsp_out;
  logic               e_i_valid;
  logic               e_i_ready;
  rsa_tpm_in_t        e_i_in;
  logic               e_o_valid;
  logic               e_o_ready;
  rsa_tpm_out_t       e_o_out;

  rsa_two_power_mod_arbiter #(.NUM_REQ(NUM_REQ)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .e_i_valid (e_i_valid),
    .e_i_ready (e_i_ready),
    .e_i_in    (e_i_in),
    .e_o_valid (e_o_valid),
    .e_o_ready (e_o_ready),
    .e_o_out   (e_o_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Square-and-multiply reference for 2^p mod m.
  function automatic logic [31:0] two_pow_mod(input logic [31:0] p, input logic [31:0] m);
    logic [63:0] r, b;
    if (m == 0) return 32'd0;
    r = 64'd1 % m;
    b = 64'd2 % m;
    for (int i = 0; i < 32; i++) begin
      if (p[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[31:0];
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];

  // ---------------- engine model ----------------
  int          eng_txns = 0;
  rsa_tpm_in_t eng_last = '0;
  int          ei_cycles = 0;
  logic        eng_hs_i, eng_hs_o, eng_busy;
  rsa_tpm_in_t eng_pay;
  int          eng_cnt;
  logic [31:0] eng_res;

  initial begin
    e_i_ready = 1'b0;
    e_o_valid = 1'b0;
    e_o_out   = '0;
    eng_busy  = 1'b0;
    eng_cnt   = 0;
    eng_res   = '0;
    forever begin
      @(negedge clk);
      eng_hs_i = rst && e_i_valid && e_i_ready;
      eng_hs_o = rst && e_o_valid && e_o_ready;
      eng_pay  = e_i_in;
      @(posedge clk);
      #1;
      if (!rst) begin
        eng_busy  = 1'b0;
        e_i_ready = 1'b0;
        e_o_valid = 1'b0;
        e_o_out   = '0;
        continue;
      end
      if (eng_hs_o) begin
        e_o_valid = 1'b0;
        eng_busy  = 1'b0;
      end
      if (eng_hs_i) begin
        eng_busy = 1'b1;
        eng_cnt  = int'($urandom_range(0, 3));
        eng_res  = two_pow_mod(eng_pay.power, eng_pay.modulus);
        eng_txns++;
        eng_last = eng_pay;
      end
      if (eng_busy && !e_o_valid) begin
        if (eng_cnt == 0) begin
          e_o_valid = 1'b1;
          e_o_out   = '{result: eng_res};
        end else begin
          eng_cnt--;
        end
      end
      e_i_ready = !eng_busy && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            sb.push_back('{idx: i,
                           res: (req_in[i].power == 0) ? 32'd1
                                : two_pow_mod(req_in[i].power, req_in[i].modulus)});
          end
        end
        if (e_i_valid) ei_cycles++;
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            check("rsp_sel", 64'(rsp_valid), 64'(1) << sb[0].idx);
            check("rsp_out", 64'(rsp_out.result), 64'(sb[0].res));
          end
          if ((rsp_valid & rsp_ready) != '0 && sb.size() != 0) void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [31:0] p, input logic [31:0] m);
    req_in[i]    = '{power: p, modulus: m};
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_any_hs(output int idx);
    idx = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) begin
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req_valid[i] && req_ready[i]) idx = i;
        @(posedge clk);
        #1;
        return;
      end
    end
    check("hs_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && rsp_valid == '0 && !e_i_valid && !e_o_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_out"}, 64'(rsp_out), 64'd0);
    check({tag, "_e_i_valid"}, 64'(e_i_valid), 64'd0);
    check({tag, "_e_o_ready"}, 64'(e_o_ready), 64'd0);
    check({tag, "_e_i_in"}, 64'(e_i_in), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int idx, e0, ei0;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) req_in[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fairness: both held from reset, grants must alternate starting at 0.
    set_req(0, 32'd4, 32'd13);
    set_req(1, 32'd5, 32'd11);
    for (int k = 0; k < 4; k++) begin
      wait_any_hs(idx);
      check("fair_grant", 64'(idx), 64'(k % 2));
    end
    req_valid = '0;
    drain();

    // Basic engine path.
    e0 = eng_txns;
    set_req(0, 32'd4, 32'd13);
    wait_any_hs(idx);
    req_valid = '0;
    check("basic_grant", 64'(idx), 64'd0);
    @(negedge clk);
    check("basic_ei_lat", 64'(e_i_valid), 64'd1);
    drain();
    check("basic_eng_txns", 64'(eng_txns - e0), 64'd1);
    check("basic_eng_pay", 64'(eng_last), {32'd4, 32'd13});

    // Zero-exponent bypass.
    e0  = eng_txns;
    ei0 = ei_cycles;
    set_req(1, 32'd0, 32'd97);
    wait_any_hs(idx);
    req_valid = '0;
    check("bypass_grant", 64'(idx), 64'd1);
    @(negedge clk);
    check("bypass_lat", 64'(rsp_valid), 64'b10);
    drain();
    check("bypass_eng_txns", 64'(eng_txns - e0), 64'd0);
    check("bypass_ei_cycles", 64'(ei_cycles - ei0), 64'd0);

    // Backpressure: other index ready must be ignored, req1 must wait.
    rsp_ready = 2'b10;
    set_req(0, 32'd4, 32'd13);
    wait_any_hs(idx);
    req_valid = '0;
    for (int c = 0; c < 200 && !rsp_valid[0]; c++) @(negedge clk);
    @(posedge clk);
    #1;
    set_req(1, 32'd5, 32'd11);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'b01);
      check("bp_rsp_out", 64'(rsp_out.result), 64'd3);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("bp_grant", 64'(req_ready), 64'b10);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Reset while waiting on the engine.
    set_req(0, 32'd7, 32'd13);
    wait_any_hs(idx);
    req_valid = '0;
    for (int c = 0; c < 200 && !e_o_ready; c++) @(negedge clk);
    check("rst_reached_wait", 64'(e_o_ready), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    e0 = eng_txns;
    set_req(0, 32'd4, 32'd13);
    set_req(1, 32'd5, 32'd11);
    wait_any_hs(idx);
    req_valid[0] = 1'b0;
    check("rst_first_grant", 64'(idx), 64'd0);
    wait_any_hs(idx);
    req_valid[1] = 1'b0;
    check("rst_second_grant", 64'(idx), 64'd1);
    drain();
    check("rst_eng_txns", 64'(eng_txns - e0), 64'd2);

    // Cache behaviour (or plain engine use when the cache is not built).
    set_req(0, 32'd4, 32'd13);
    wait_any_hs(idx);
    req_valid = '0;
    drain();
    e0 = eng_txns;
    set_req(1, 32'd4, 32'd13);
    wait_any_hs(idx);
    req_valid = '0;
    @(negedge clk);
`ifdef RSA_TPM_CACHE_EN
    check("cache_lat", 64'(rsp_valid), 64'b10);
`else
    check("cache_lat", 64'(rsp_valid), 64'b00);
`endif
    drain();
`ifdef RSA_TPM_CACHE_EN
    check("cache_hit_txns", 64'(eng_txns - e0), 64'd0);
`else
    check("cache_hit_txns", 64'(eng_txns - e0), 64'd1);
`endif
    e0 = eng_txns;
    set_req(0, 32'd5, 32'd13);
    wait_any_hs(idx);
    req_valid = '0;
    drain();
    check("cache_miss_txns", 64'(eng_txns - e0), 64'd1);

    // Random mix across requesters.
    for (int n = 0; n < 12; n++) begin
      int i;
      i = int'($urandom_range(0, NUM_REQ - 1));
      set_req(i, 32'($urandom_range(0, 40)), 32'($urandom_range(2, 1000)));
      wait_any_hs(idx);
      req_valid = '0;
      check("rand_grant", 64'(idx), 64'(i));
      drain();
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
